// File: rtl/jk_excite_driver_if.sv
// rtl/jk_excite_driver_if.sv - handshake and JK drive bundle between controller and bank
interface jk_excite_driver_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start,
        output target,
        output q_fb,
        input  j,
        input  k,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  target,
        input  q_fb,
        output j,
        output k,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - drives a JK flip-flop bank to a target value with compare and bounded retry
// Optional JK_TOGGLE_EXCITE_EN selects toggle-style excitation instead of set/reset drive.
module jk_excite_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input logic               clk,
    input logic               clr,
    jk_excite_driver_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [2:0]       retry;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic [WIDTH-1:0] load_tgt;
    logic [WIDTH-1:0] load_j;
    logic [WIDTH-1:0] load_k;
    logic             match;

    // On the accepting edge tgt_r is not yet valid, so excite from the live target.
    assign load_tgt = (state == IDLE) ? bus.target : tgt_r;
    assign match    = (bus.q_fb == tgt_r);

`ifdef JK_TOGGLE_EXCITE_EN
    assign load_j = bus.q_fb ^ load_tgt;
    assign load_k = bus.q_fb ^ load_tgt;
`else
    assign load_j = load_tgt;
    assign load_k = ~load_tgt;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            tgt_r  <= '0;
            j_r    <= '0;
            k_r    <= '0;
            retry  <= 3'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            // Drive is a single-cycle pulse; default everything back to quiet.
            j_r    <= '0;
            k_r    <= '0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt_r  <= bus.target;
                        err_r  <= 1'b0;
                        retry  <= 3'd0;
                        j_r    <= load_j;
                        k_r    <= load_k;
                        busy_r <= 1'b1;
                        state  <= APPLY;
                    end
                end
                APPLY: begin
                    state <= HOLD;
                end
                HOLD: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (match) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (retry < 3'(MAX_RETRY)) begin
                        retry <= retry + 3'd1;
                        j_r   <= load_j;
                        k_r   <= load_k;
                        state <= APPLY;
                    end else begin
                        err_r  <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.j    = j_r;
    assign bus.k    = k_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - scoreboard bench for jk_excite_driver with a behavioural JK bank
module tb_jk_excite_driver;
    localparam int W  = 4;
    localparam int MR = 2;

    logic clk;
    logic clr;
    jk_excite_driver_if #(.WIDTH(W)) bus ();

    jk_excite_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        bit ok;
        int lat;
        int acc;
    } sb_t;

    sb_t          sbq[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           edge_cnt = 0;
    logic [W-1:0] s0 = '0;
    logic [W-1:0] s1 = '0;
    logic [W-1:0] mq = '0;
    logic         preset_req = 1'b0;
    logic [W-1:0] preset_val = '0;
    logic         err_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // External JK bank with optional stuck-at-0 (s0) / stuck-at-1 (s1) bits
    always @(posedge clk) begin
        if (preset_req)
            bus.q_fb <= (preset_val & ~s0) | s1;
        else
            bus.q_fb <= (((bus.j & ~bus.q_fb) | (~bus.k & bus.q_fb)) & ~s0) | s1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: one applied drive leaves every healthy bit at its target,
    // stuck bits never move, so retries cannot fix a mismatch.
    task automatic predict(input logic [W-1:0] q0, input logic [W-1:0] t,
                           output bit ok, output int lat,
                           output logic [W-1:0] ej, output logic [W-1:0] ek,
                           output logic [W-1:0] qa);
        qa  = (t & ~s0) | s1;
        ok  = (qa == t);
        lat = ok ? 3 : 3 * (MR + 1);
`ifdef JK_TOGGLE_EXCITE_EN
        ej = q0 ^ t;
        ek = q0 ^ t;
`else
        ej = t;
        ek = ~t;
`endif
    endtask

    task automatic accepted(input logic [W-1:0] t);
        bit           ok;
        int           lat;
        logic [W-1:0] ej, ek, qa;
        predict(mq, t, ok, lat, ej, ek, qa);
        sbq.push_back('{ok: ok, lat: lat, acc: edge_cnt});
        chk("load_j", bus.j, ej);
        chk("load_k", bus.k, ek);
        chk("busy_on_accept", bus.busy, 1);
        chk("err_clear_on_accept", bus.err, 0);
        mq = qa;
    endtask

    task automatic set_bank(input logic [W-1:0] v, input logic [W-1:0] m0, input logic [W-1:0] m1);
        s0 = m0;
        s1 = m1;
        preset_val = v;
        preset_req = 1'b1;
        @(posedge clk);
        #1;
        preset_req = 1'b0;
        mq = (v & ~m0) | m1;
    endtask

    task automatic issue(input logic [W-1:0] t, input bit track);
        bus.start  = 1'b1;
        bus.target = t;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.target = W'($urandom);
        if (track) accepted(t);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) break;
        end
        if (sbq.size() != 0) begin
            chk("response_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            if (bus.done || (bus.err && !err_q)) begin
                chk("done_err_exclusive", bus.done & bus.err, 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_response", {bus.done, bus.err}, 0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("outcome_done", bus.done, e.ok);
                    chk("latency", edge_cnt - e.acc, e.lat);
                end
            end
        end
        err_q = bus.err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           acc;
        int           next_acc;
        logic [W-1:0] t;
        clr        = 1'b0;
        bus.start  = 1'b0;
        bus.target = '0;
        set_bank('0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_j", bus.j, 0);
        chk("rst_k", bus.k, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        clr = 1'b1;

        // First edge after release accepts; bank at 0000, target 1010
        issue(4'b1010, 1'b1);
        wait_idle();
        chk("bank_after_1010", bus.q_fb, 4'b1010);

        set_bank(4'b0110, '0, '0);
        issue(4'b0101, 1'b1);
        wait_idle();
        chk("bank_after_0101", bus.q_fb, 4'b0101);

        // Bit0 stuck low: all retries fail, err after 9 edges
        set_bank('0, 4'b0001, '0);
        issue(4'b0001, 1'b1);
        wait_idle();
        chk("err_sticky", bus.err, 1);
        chk("busy_after_err", bus.busy, 0);
        repeat (3) @(negedge clk);
        chk("err_still_sticky", bus.err, 1);

        set_bank('0, '0, '0);
        issue(4'b0000, 1'b1);
        wait_idle();
        chk("err_after_recovery", bus.err, 0);

        // Abort mid-APPLY: outputs clear without a clock edge, no response follows
        issue(4'b1111, 1'b0);
        #1;
        clr = 1'b0;
        #1;
        chk("abort_j", bus.j, 0);
        chk("abort_k", bus.k, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_err", bus.err, 0);
        @(negedge clk);
        clr = 1'b1;
        issue(4'b0011, 1'b1);
        wait_idle();

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] m0, m1;
            m0 = '0;
            m1 = '0;
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) m0 = W'(1 << $urandom_range(W - 1));
                else                        m1 = W'(1 << $urandom_range(W - 1));
            end
            set_bank(W'($urandom), m0, m1);
            issue(W'($urandom), 1'b1);
            wait_idle();
        end

        // start held high with a new target every cycle
        set_bank(W'($urandom), '0, '0);
        acc       = -100;
        next_acc  = edge_cnt + 1;
        bus.start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            t = W'($urandom);
            bus.target = t;
            @(posedge clk);
            #1;
            if (edge_cnt == next_acc) begin
                accepted(t);
                acc      = edge_cnt;
                next_acc = edge_cnt + 4;
            end
            chk("spam_busy", bus.busy, ((edge_cnt - acc) < 3) ? 1 : 0);
        end
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
